// File: rtl/spi_mcp320x_scan.sv
// Round-robin scanner for an MCP320x-family SPI ADC.
// Each frame of SAMPLE_PERIOD clocks, the scanner picks the next enabled
// channel and runs one 19-SCK conversion. It then presents the 12-bit
// result on o_data/o_ch with a one-cycle o_valid pulse.
module spi_mcp320x_scan #(
    parameter int NUM_CH        = 8,
    parameter int SGL           = 1,
    parameter int CLK_DIV       = 70,
    parameter int SAMPLE_PERIOD = 3000,
    parameter int TSU           = 56,
    parameter int TCSH          = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              miso,
    output logic              mosi,
    output logic              sck,
    output logic              cs_n,
    output logic [11:0]       o_data,
    output logic [2:0]        o_ch,
    output logic              o_valid,
    output logic              o_busy
);

    if (SAMPLE_PERIOD < TSU + 38 * CLK_DIV + TCSH + 2) begin : g_bad_period
        $error("spi_mcp320x_scan: SAMPLE_PERIOD too short for one conversion");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("spi_mcp320x_scan: NUM_CH must be 1..8");
    end
    if (CLK_DIV < 2 || TSU < 1 || TCSH < 1) begin : g_bad_timing
        $error("spi_mcp320x_scan: CLK_DIV >= 2, TSU >= 1, TCSH >= 1 required");
    end

    localparam int FW    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TMAX0 = (TSU > 2 * CLK_DIV) ? TSU : 2 * CLK_DIV;
    localparam int TMAX  = (TMAX0 > TCSH) ? TMAX0 : TCSH;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t        state, state_nx;
    logic [FW-1:0] fcnt;
    logic [TW-1:0] tmr, tmr_nx;
    logic [4:0]    bitn, bitn_nx;
    logic [2:0]    ch, ch_nx;
    logic [2:0]    last_ch, last_nx;
    logic          have_last, have_nx;
    logic [11:0]   sr, sr_nx;
    logic          cs_nx, sck_nx, mosi_nx, valid_nx;
    logic [11:0]   data_nx;
    logic [2:0]    och_nx;
    logic [7:0]    mask8;
    logic [2:0]    sel;
    logic          frame_start;

    // Command word shifted out MSB first: start, SGL/DIFF, D2, D1, D0, then zeros.
    function automatic logic cmd_bit(input logic [4:0] idx, input logic [2:0] c);
        case (idx)
            5'd0:    return 1'b1;
            5'd1:    return (SGL != 0);
            5'd2:    return c[2];
            5'd3:    return c[1];
            5'd4:    return c[0];
            default: return 1'b0;
        endcase
    endfunction

    assign frame_start = en && (fcnt == '0);
    assign o_busy      = ~cs_n;

    // Frame counter: free-runs over the sample period while enabled, parked at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= '0;
        end else if (!en) begin
            fcnt <= '0;
        end else if (fcnt == FW'(SAMPLE_PERIOD - 1)) begin
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end

    // Round-robin pick: lowest enabled channel, overridden by the first enabled one above the last.
    always_comb begin
        logic found_above;
        logic found_low;
        mask8              = '0;
        mask8[NUM_CH-1:0]  = ch_mask;
        sel                = '0;
        found_low          = 1'b0;
        found_above        = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (mask8[i[2:0]] && !found_low) begin
                sel       = i[2:0];
                found_low = 1'b1;
            end
        end
        for (int unsigned i = 0; i < 8; i++) begin
            if (mask8[i[2:0]] && have_last && (i[2:0] > last_ch) && !found_above) begin
                sel         = i[2:0];
                found_above = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmr       <= '0;
            bitn      <= '0;
            ch        <= '0;
            last_ch   <= '0;
            have_last <= 1'b0;
            sr        <= '0;
            cs_n      <= 1'b1;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            o_data    <= '0;
            o_ch      <= '0;
            o_valid   <= 1'b0;
        end else begin
            state     <= state_nx;
            tmr       <= tmr_nx;
            bitn      <= bitn_nx;
            ch        <= ch_nx;
            last_ch   <= last_nx;
            have_last <= have_nx;
            sr        <= sr_nx;
            cs_n      <= cs_nx;
            sck       <= sck_nx;
            mosi      <= mosi_nx;
            o_data    <= data_nx;
            o_ch      <= och_nx;
            o_valid   <= valid_nx;
        end
    end

    // Next-state, SPI pin and capture logic; en=0 overrides everything at the end.
    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        bitn_nx  = bitn;
        ch_nx    = ch;
        last_nx  = last_ch;
        have_nx  = have_last;
        sr_nx    = sr;
        cs_nx    = cs_n;
        sck_nx   = sck;
        mosi_nx  = mosi;
        data_nx  = o_data;
        och_nx   = o_ch;
        valid_nx = 1'b0;

        case (state)
            IDLE: begin
                if (frame_start && (ch_mask != '0)) begin
                    state_nx = SETUP;
                    ch_nx    = sel;
                    last_nx  = sel;
                    have_nx  = 1'b1;
                    cs_nx    = 1'b0;
                    mosi_nx  = cmd_bit(5'd0, sel);
                    tmr_nx   = '0;
                end
            end
            SETUP: begin
                if (tmr == TW'(TSU - 1)) begin
                    state_nx = SHIFT;
                    sck_nx   = 1'b1;
                    tmr_nx   = '0;
                    bitn_nx  = '0;
                end else begin
                    tmr_nx = tmr + 1'b1;
                end
            end
            SHIFT: begin
                tmr_nx = tmr + 1'b1;
                // sr already holds the bit taken on rise 19 in the cycle that rise is visible.
                if (tmr == '0 && bitn == 5'd18) begin
                    data_nx  = sr;
                    och_nx   = ch;
                    valid_nx = 1'b1;
                end
                if (tmr == TW'(CLK_DIV - 1)) begin
                    sck_nx  = 1'b0;
                    mosi_nx = cmd_bit(bitn + 5'd1, ch);
                end
                if (tmr == TW'(CLK_DIV) && bitn == 5'd18) begin
                    state_nx = HOLD;
                    cs_nx    = 1'b1;
                    mosi_nx  = 1'b0;
                    tmr_nx   = '0;
                end
                if (tmr == TW'(2 * CLK_DIV - 1)) begin
                    sck_nx  = 1'b1;
                    tmr_nx  = '0;
                    bitn_nx = bitn + 5'd1;
                    // Rises 8..19 carry B11..B0; earlier rises are sample/null time.
                    if (bitn >= 5'd6) begin
                        sr_nx = {sr[10:0], miso};
                    end
                end
            end
            HOLD: begin
                if (tmr == TW'(TCSH - 1)) begin
                    state_nx = IDLE;
                    tmr_nx   = '0;
                end else begin
                    tmr_nx = tmr + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (!en) begin
            state_nx = IDLE;
            tmr_nx   = '0;
            have_nx  = 1'b0;
            cs_nx    = 1'b1;
            sck_nx   = 1'b0;
            mosi_nx  = 1'b0;
            data_nx  = o_data;
            och_nx   = o_ch;
            valid_nx = 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_mcp320x_scan.sv
// Bench for spi_mcp320x_scan. It runs two instances: defaults, and SGL=0 with NUM_CH=4.
// Each instance has a behavioural ADC. A frame-offset reference model is checked every cycle.
module tb_spi_mcp320x_scan;

    localparam int CD   = 70;
    localparam int TSU  = 56;
    localparam int TCSH = 64;
    localparam int SP   = 3000;
    localparam int S    = 1 + TSU;              // offset of first SCK rise from F
    localparam int VO   = S + 1 + 36 * CD;      // offset of o_valid
    localparam int CSH  = S + 37 * CD + 1;      // offset where cs_n is high again

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  mask = 8'h01;
    logic [1:0]  miso_v = '0;
    logic [1:0]  mosi_v, sck_v, cs_v, valid_v, busy_v;
    logic [11:0] data_v [2];
    logic [2:0]  och_v  [2];

    spi_mcp320x_scan dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(mask), .miso(miso_v[0]),
        .mosi(mosi_v[0]), .sck(sck_v[0]), .cs_n(cs_v[0]), .o_data(data_v[0]),
        .o_ch(och_v[0]), .o_valid(valid_v[0]), .o_busy(busy_v[0])
    );

    spi_mcp320x_scan #(.NUM_CH(4), .SGL(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(mask[3:0]), .miso(miso_v[1]),
        .mosi(mosi_v[1]), .sck(sck_v[1]), .cs_n(cs_v[1]), .o_data(data_v[1]),
        .o_ch(och_v[1]), .o_valid(valid_v[1]), .o_busy(busy_v[1])
    );

    initial forever #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    int          fc = 0;
    bit          act   [2];
    longint      fstart[2];
    logic [2:0]  mch   [2];
    logic [2:0]  mlast [2];
    bit          mhave [2];
    logic [11:0] mword [2];
    logic [11:0] mdata [2];
    logic [2:0]  mo_ch [2];
    int          force_word = -1;
    logic [4:0]  adc_cmd [2];
    int          rises   [2];
    logic        prev_sck[2];
    logic [2:0]  vq0[$];
    logic [2:0]  vq1[$];
    int          lowcnt = 0;

    task automatic chk(input string name, input int d, input longint act_v, input longint exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("FAIL %s dut%0d cycle=%0d got=%0h expected=%0h", name, d, cyc, act_v, exp_v);
        end
    endtask

    // Round-robin: scan upward from just past the last channel, wrapping.
    function automatic logic [2:0] pick(input logic [7:0] mk, input bit have,
                                        input logic [2:0] last, input int nch);
        int start;
        int c;
        start = have ? int'(last) + 1 : 0;
        for (int s = 0; s < nch; s++) begin
            c = (start + s) % nch;
            if (mk[c[2:0]]) return c[2:0];
        end
        return 3'd0;
    endfunction

    // Reference model advance at each edge, then compare every output one step later.
    always @(posedge clk) begin
        logic [7:0] mk;
        logic [4:0] cmd;
        longint     o;
        int         k;
        logic       e_cs, e_sck, e_mosi, e_valid;
        bit         mosi_chk;
        if (!rst_n) begin
            fc = 0;
            for (int d = 0; d < 2; d++) begin
                act[d] = 0; mhave[d] = 0; mdata[d] = '0; mo_ch[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                mk = (d == 0) ? mask : {4'b0000, mask[3:0]};
                if (!en) begin
                    act[d] = 0;
                    mhave[d] = 0;
                end else if (fc == 0 && mk != 8'h00) begin
                    mch[d]    = pick(mk, mhave[d], mlast[d], (d == 0) ? 8 : 4);
                    mlast[d]  = mch[d];
                    mhave[d]  = 1;
                    act[d]    = 1;
                    fstart[d] = cyc;
                    mword[d]  = (force_word >= 0) ? 12'(force_word) : 12'($urandom);
                end
            end
            fc = en ? (fc + 1) % SP : 0;
        end
        cyc++;
        #1;
        for (int d = 0; d < 2; d++) begin
            e_cs = 1'b1; e_sck = 1'b0; e_mosi = 1'b0; e_valid = 1'b0; mosi_chk = 1;
            if (act[d]) begin
                o = cyc - fstart[d];
                if (o >= CSH) begin
                    act[d] = 0;
                end else begin
                    e_cs = 1'b0;
                    mosi_chk = 0;
                    cmd = {1'b1, (d == 0) ? 1'b1 : 1'b0, mch[d]};
                    if (o >= S && o < S + 37 * CD && ((o - S) % (2 * CD)) < CD) e_sck = 1'b1;
                    if (o >= S && ((o - S) % (2 * CD)) == 0 && ((o - S) / (2 * CD)) < 19) begin
                        k = int'((o - S) / (2 * CD)) + 1;
                        mosi_chk = 1;
                        e_mosi = (k <= 5) ? cmd[5 - k] : 1'b0;
                        if (k == 6) chk("adc_cmd", d, adc_cmd[d], cmd);
                    end
                    if (o == VO) begin
                        e_valid  = 1'b1;
                        mdata[d] = mword[d];
                        mo_ch[d] = mch[d];
                    end
                end
            end
            chk("cs_n", d, cs_v[d], e_cs);
            chk("sck", d, sck_v[d], e_sck);
            if (mosi_chk) chk("mosi", d, mosi_v[d], e_mosi);
            chk("o_valid", d, valid_v[d], e_valid);
            chk("o_busy", d, busy_v[d], !e_cs);
            chk("o_data", d, data_v[d], mdata[d]);
            chk("o_ch", d, och_v[d], mo_ch[d]);
        end
        if (valid_v[0]) vq0.push_back(och_v[0]);
        if (valid_v[1]) vq1.push_back(och_v[1]);
        if (!cs_v[0]) lowcnt++;
    end

    // Behavioural ADC: decodes Din on rises 1..5; shifts the word out after falls 7..18.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cs_v[d]) begin
                rises[d]  = 0;
                miso_v[d] = 1'($urandom);
            end else if (sck_v[d] && !prev_sck[d]) begin
                rises[d]++;
                if (rises[d] <= 5) adc_cmd[d] = {adc_cmd[d][3:0], mosi_v[d]};
            end else if (!sck_v[d] && prev_sck[d]) begin
                if (rises[d] >= 7 && rises[d] <= 18) miso_v[d] = mword[d][18 - rises[d]];
                else miso_v[d] = 1'($urandom);
            end
            prev_sck[d] = sck_v[d];
        end
    end

    // Advance to one step after the edge that starts cycle t.
    task automatic goto(input longint t);
        int n;
        n = int'(t - cyc);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        longint f0, f1;
        int     n;
        int     exp_seq [4] = '{1, 5, 7, 1};
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_cs_n", d, cs_v[d], 1);
            chk("rst_o_data", d, data_v[d], 0);
            chk("rst_o_valid", d, valid_v[d], 0);
        end

        // Single-channel frame with a fixed ADC word.
        @(posedge clk); #2;
        force_word = 12'hA5C;
        en = 1'b1;
        f0 = cyc;
        goto(f0 + 2578);
        for (int d = 0; d < 2; d++) begin
            chk("lit_valid", d, valid_v[d], 1);
            chk("lit_data", d, data_v[d], 12'hA5C);
            chk("lit_ch", d, och_v[d], 0);
        end
        chk("lit_cmd", 0, adc_cmd[0], 5'b11000);
        chk("lit_cmd", 1, adc_cmd[1], 5'b10000);
        goto(f0 + 2647);
        chk("lit_cs_low", 0, cs_v[0], 0);
        goto(f0 + 2648);
        chk("lit_cs_high", 0, cs_v[0], 1);
        chk("lit_busy_low", 0, busy_v[0], 0);

        // Round-robin over four frames.
        #1;
        force_word = -1;
        mask = 8'b1010_0010;
        vq0.delete(); vq1.delete();
        goto(f0 + 14648);
        chk("rr_count", 0, vq0.size(), 4);
        chk("rr_count", 1, vq1.size(), 4);
        for (int i = 0; i < vq0.size() && i < 4; i++) chk("rr_seq", 0, vq0[i], exp_seq[i]);
        for (int i = 0; i < vq1.size() && i < 4; i++) chk("rr_seq", 1, vq1[i], 1);

        // Enable dropped mid-conversion, then re-enabled.
        goto(f0 + 16000);
        #1 en = 1'b0;
        goto(f0 + 16001);
        chk("drop_cs_n", 0, cs_v[0], 1);
        chk("drop_sck", 0, sck_v[0], 0);
        n = vq0.size();
        goto(f0 + 16010);
        #1 en = 1'b1;
        f1 = cyc;
        goto(f1 + 2578);
        chk("reen_valid", 0, valid_v[0], 1);
        chk("reen_ch", 0, och_v[0], 1);
        goto(f1 + 2600);
        chk("reen_count", 0, vq0.size(), n + 1);

        // Empty mask for three frames, then channel 7 only.
        #1 mask = 8'h00;
        goto(f1 + 2700);
        lowcnt = 0;
        goto(f1 + 11000);
        chk("empty_cs_low_cycles", 0, lowcnt, 0);
        #1 mask = 8'h80;
        goto(f1 + 12000 + 2578);
        chk("ch7_valid", 0, valid_v[0], 1);
        chk("ch7_ch", 0, och_v[0], 7);

        // Asynchronous reset in the middle of SHIFT.
        goto(f1 + 15000 + 500);
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("arst_cs_n", d, cs_v[d], 1);
            chk("arst_sck", d, sck_v[d], 0);
            chk("arst_mosi", d, mosi_v[d], 0);
            chk("arst_data", d, data_v[d], 0);
            chk("arst_ch", d, och_v[d], 0);
            chk("arst_valid", d, valid_v[d], 0);
            chk("arst_busy", d, busy_v[d], 0);
        end
        en = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        en = 1'b1;

        // Randomised mask changes and enable drops.
        for (int it = 0; it < 10; it++) begin
            goto(cyc + longint'($urandom_range(200, 3500)));
            #1;
            mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                en = 1'b0;
                goto(cyc + longint'($urandom_range(1, 40)));
                #1 en = 1'b1;
            end
        end
        goto(cyc + 3100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
